fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
// Forwarding and load-use hazard control for the 5-stage RV32I pipeline. Tracks the
// destination registers of the instructions in EX, MEM and WB internally. Produces
// registered 2-bit selects for the two EX-stage ALU-operand 3:1 muxes
// (00=ID/EX regfile data, 01=MEM/WB writeback data, 10=EX/MEM ALU result).
// Generates the one-cycle load-use stall and a saturating stall counter.
// PARAMETERS
// REG_ADDR_W  5   register index width
// CNT_W       16  width of stall_count
// PORTS
// clk           in   1           pipeline clock, all state on rising edge
// rst_n         in   1           asynchronous active-low reset
// id_valid      in   1           ID holds a real instruction
// id_rs1        in   REG_ADDR_W  ID source register 1
// id_rs2        in   REG_ADDR_W  ID source register 2
// id_rd         in   REG_ADDR_W  ID destination register
// id_reg_write  in   1           ID instruction writes rd
// id_mem_read   in   1           ID instruction is a load
// ex_flush      in   1           taken branch/jump resolved in EX; kill ID instruction
// fwd_a         out  2           select for ALU operand A mux (EX stage), registered
// fwd_b         out  2           select for ALU operand B mux (EX stage), registered
// stall         out  1           combinational; hold PC and IF/ID, bubble into ID/EX
// stall_count   out  CNT_W       number of stall cycles since reset, saturating
// BEHAVIOUR
// - Reset (async, rst_n=0): EX/MEM/WB tracking slots invalid, fwd_a=fwd_b=2'b00,
//   stall_count=0. stall=0 because the EX slot is invalid.
// - Slot = {valid, rd, reg_write, mem_read}. A slot "writes r" iff valid & reg_write &
//   rd==r & r!=0. Register x0 never forwards and never stalls.
// - stall = id_valid & EX.valid & EX.mem_read & EX.reg_write & EX.rd!=0 &
//   (EX.rd==id_rs1 | EX.rd==id_rs2) & !ex_flush. A match on either source stalls,
//   whether or not the instruction uses that operand.
// - Each clock: WB<=MEM, MEM<=EX.
//   EX<=bubble (valid=0) if stall|ex_flush|!id_valid, else EX<=ID fields.
// - fwd_a next value is computed from id_rs1 against the pre-edge slots. EX becomes
//   EX/MEM next cycle; MEM becomes MEM/WB next cycle.
//   * 10 if the EX slot writes rs1 and is not a load;
//   * else 01 if the MEM slot writes rs1 (load or ALU);
//   * else 00.
//   fwd_b is computed the same way from id_rs2.
// - The youngest producer wins: EX beats MEM. A WB-slot producer gives 00; the register
//   file is write-before-read and covers that case.
// - On stall, ex_flush or !id_valid: fwd_a/fwd_b<=00 (bubble). The stalled ID instruction
//   is re-evaluated next cycle, when the load sits in MEM, and gets select 01.
// - Load-use latency: exactly one stall cycle per dependent load, then the value
//   forwards from MEM/WB.
// - ex_flush has priority over stall. A flushed cycle is not counted as a stall.
// - stall_count increments on every cycle with stall=1. It holds at 2^CNT_W-1 and
//   does not wrap.
// - Reset asserted mid-stall clears all state at once. stall drops asynchronously
//   with the EX slot.
// TESTING
// - Reset: rst_n=0 mid-run -> fwd_a=fwd_b=00, stall=0, stall_count=0 immediately.
// - EX forward: add x5,x1,x2 then sub x6,x5,x3 -> in sub's EX cycle fwd_a=10, fwd_b=00.
// - MEM forward and priority:
//   * add x5; nop; or x7,x3,x5 -> or's EX cycle: fwd_b=01.
//   * add x5; add x5; or x7,x5,x5 -> fwd_a=fwd_b=10.
// - Load-use: lw x4,0(x1) then add x8,x4,x4 -> stall=1 for exactly 1 cycle.
//   Bubble enters EX with fwd=00. Add's EX cycle gets fwd_a=fwd_b=01. stall_count=1.
// - x0 and flush:
//   * add x0,... then use x0 -> fwd=00, no stall.
//   * lw x4 with a dependent in ID plus ex_flush=1 -> stall=0, EX bubble, count unchanged.
// - Saturation: CNT_W=4, force 20 load-use stalls -> stall_count sticks at 15.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall control for the 5-stage RV32I pipeline.
// Tracks in-flight producers and registers the EX-stage ALU operand mux selects.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } ex_slot_t;

  // A MEM producer forwards whether or not it is a load, and a WB producer is
  // covered by the write-before-read register file, so neither keeps mem_read.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } mem_slot_t;

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_MEM_WB  = 2'b01;
  localparam logic [1:0] SEL_EX_MEM  = 2'b10;

  ex_slot_t  ex_q;
  mem_slot_t mem_q;
  logic      load_in_ex;
  logic      bubble;

  function automatic logic writes(input logic valid, input logic reg_write,
                                  input logic [REG_ADDR_W-1:0] rd,
                                  input logic [REG_ADDR_W-1:0] r);
    return valid && reg_write && (rd == r) && (r != '0);
  endfunction

  // Youngest producer wins; a load still in EX cannot forward (that case stalls).
  function automatic logic [1:0] fwd_sel(input ex_slot_t ex, input mem_slot_t mem,
                                         input logic [REG_ADDR_W-1:0] r);
    if (writes(ex.valid, ex.reg_write, ex.rd, r) && !ex.mem_read) return SEL_EX_MEM;
    if (writes(mem.valid, mem.reg_write, mem.rd, r))             return SEL_MEM_WB;
    return SEL_REGFILE;
  endfunction

  assign load_in_ex = ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.rd != '0);
  assign stall      = id_valid && load_in_ex &&
                      ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2)) && !ex_flush;
  assign bubble     = stall || ex_flush || !id_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge slot values, which is exactly what the forwarding compare needs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      fwd_a       <= SEL_REGFILE;
      fwd_b       <= SEL_REGFILE;
      stall_count <= '0;
    end else begin
      mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
      if (bubble) begin
        ex_q  <= '0;
        fwd_a <= SEL_REGFILE;
        fwd_b <= SEL_REGFILE;
      end else begin
        ex_q  <= '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
        fwd_a <= fwd_sel(ex_q, mem_q, id_rs1);
        fwd_b <= fwd_sel(ex_q, mem_q, id_rs2);
      end
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding selects, load-use stall,
// x0 handling, flush priority, asynchronous reset and counter saturation.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read, ex_flush;
  logic [1:0] fwd_a, fwd_b;
  logic       stall;
  logic [3:0] stall_count;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_reg_write(id_reg_write),
    .id_mem_read (id_mem_read),
    .ex_flush    (ex_flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    ex_flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("reset_fwd_a", 16'(fwd_a), 16'h0);
    check("reset_fwd_b", 16'(fwd_b), 16'h0);
    check("reset_stall", 16'(stall), 16'h0);
    check("reset_count", 16'(stall_count), 16'h0);
    tick();
    rst_n = 1'b1;
    idle(2);

    // EX forward: add x5,x1,x2 ; sub x6,x5,x3
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0);
    check("exfwd_stall", 16'(stall), 16'h0);
    tick();
    check("exfwd_a", 16'(fwd_a), 16'h2);
    check("exfwd_b", 16'(fwd_b), 16'h0);
    idle(3);

    // MEM forward: add x5 ; nop ; or x7,x3,x5
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    idle(1);
    drive(1'b1, 5'd3, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0); tick();
    check("memfwd_a", 16'(fwd_a), 16'h0);
    check("memfwd_b", 16'(fwd_b), 16'h1);
    idle(3);

    // Priority: add x5 ; add x5 ; or x7,x5,x5 -> EX beats MEM
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0); tick();
    check("prio_a", 16'(fwd_a), 16'h2);
    check("prio_b", 16'(fwd_b), 16'h2);
    idle(3);

    // WB-slot producer is left to the register file
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    idle(2);
    drive(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0); tick();
    check("wb_a", 16'(fwd_a), 16'h0);
    idle(3);

    // Load-use: lw x4,0(x1) ; add x8,x4,x4
    drive(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
    check("lw_no_stall", 16'(stall), 16'h0);
    tick();
    drive(1'b1, 5'd4, 5'd4, 5'd8, 1'b1, 1'b0, 1'b0);
    check("lu_stall", 16'(stall), 16'h1);
    tick();
    check("lu_bubble_a", 16'(fwd_a), 16'h0);
    check("lu_bubble_b", 16'(fwd_b), 16'h0);
    check("lu_count", 16'(stall_count), 16'h1);
    check("lu_stall_once", 16'(stall), 16'h0);
    tick();
    check("lu_fwd_a", 16'(fwd_a), 16'h1);
    check("lu_fwd_b", 16'(fwd_b), 16'h1);
    check("lu_count_hold", 16'(stall_count), 16'h1);
    idle(3);

    // x0 never forwards or stalls
    drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    check("x0_alu_stall", 16'(stall), 16'h0);
    tick();
    check("x0_alu_a", 16'(fwd_a), 16'h0);
    check("x0_alu_b", 16'(fwd_b), 16'h0);
    idle(3);
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    check("x0_load_stall", 16'(stall), 16'h0);
    idle(3);

    // Flush beats stall: lw x4 ; add x8,x4,x4 with ex_flush
    drive(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd4, 5'd4, 5'd8, 1'b1, 1'b0, 1'b1);
    check("flush_stall", 16'(stall), 16'h0);
    tick();
    check("flush_fwd_a", 16'(fwd_a), 16'h0);
    check("flush_count", 16'(stall_count), 16'h1);
    // EX must now hold a bubble (not add x8); MEM still holds lw x4
    drive(1'b1, 5'd8, 5'd4, 5'd10, 1'b1, 1'b0, 1'b0);
    check("flush_after_stall", 16'(stall), 16'h0);
    tick();
    check("flush_ex_bubble", 16'(fwd_a), 16'h0);
    check("flush_mem_fwd", 16'(fwd_b), 16'h1);
    idle(3);

    // Reset asserted mid-stall
    drive(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd4, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    check("pre_rst_stall", 16'(stall), 16'h1);
    rst_n = 1'b0;
    #1;
    check("rst_stall", 16'(stall), 16'h0);
    check("rst_count", 16'(stall_count), 16'h0);
    check("rst_fwd_a", 16'(fwd_a), 16'h0);
    check("rst_fwd_b", 16'(fwd_b), 16'h0);
    #1;
    rst_n = 1'b1;
    idle(3);

    // Saturation with CNT_W=4: 20 load-use stalls
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0); tick();
      drive(1'b1, 5'd4, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0); tick();
      tick();
      if (i == 13) check("sat_count_14", 16'(stall_count), 16'd14);
    end
    check("sat_count_15", 16'(stall_count), 16'd15);
    idle(2);
    check("sat_final", 16'(stall_count), 16'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
